// File: rtl/axil_interconnect_pkg.sv
// Shared types and sizing helpers for the AXI-Lite interconnect write arbiter.
package axil_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } axil_wr_arb_state_t;

  function automatic int slv_idx_width(input int number_slave);
    return (number_slave > 1) ? $clog2(number_slave) : 1;
  endfunction

  function automatic int mst_idx_width(input int number_master);
    return (number_master > 1) ? $clog2(number_master) : 1;
  endfunction

endpackage

// File: rtl/axil_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module axil_rr_arbiter
  import axil_interconnect_pkg::*;
#(
  parameter int NUMBER_MASTER = 3,
  localparam int MW = mst_idx_width(NUMBER_MASTER)
) (
  input  logic [NUMBER_MASTER-1:0] req,
  input  logic [MW-1:0]            ptr,
  output logic [NUMBER_MASTER-1:0] grant,
  output logic [MW-1:0]            grant_idx,
  output logic                     valid
);

  always_comb begin
    int c;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a variable unassigned, which would infer a latch.
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    c         = 0;
    for (int k = 0; k < NUMBER_MASTER; k++) begin
      c = (int'(ptr) + k) % NUMBER_MASTER;
      if (!valid && req[c]) begin
        valid     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = MW'(c);
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-channel arbiter: per-slave round-robin grant held across AW/W/B.
module axil_arbiter_wr
  import axil_interconnect_pkg::*;
#(
  parameter int NUMBER_MASTER  = 3,
  parameter int NUMBER_SLAVE   = 4,
  parameter int AXI_ADDR_WIDTH = 8
) (
  input  logic                                                 aclk,
  input  logic                                                 aresetn,
  input  logic [NUMBER_MASTER-1:0][AXI_ADDR_WIDTH-1:0]         m_axil_awaddr,
  input  logic [NUMBER_MASTER-1:0]                             m_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]                              s_axil_awvalid,
  input  logic [NUMBER_SLAVE-1:0]                              s_axil_awready,
  input  logic [NUMBER_SLAVE-1:0]                              s_axil_wvalid,
  input  logic [NUMBER_SLAVE-1:0]                              s_axil_wready,
  input  logic [NUMBER_SLAVE-1:0]                              s_axil_bvalid,
  input  logic [NUMBER_SLAVE-1:0]                              s_axil_bready,
  output logic [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0]           grant_wr,
  output logic [NUMBER_SLAVE-1:0][$clog2(NUMBER_MASTER)-1:0]   grant_wr_cdr,
  output logic [NUMBER_MASTER-1:0][NUMBER_SLAVE-1:0]           grant_wr_trans,
  output logic [NUMBER_MASTER-1:0][$clog2(NUMBER_SLAVE)-1:0]   grant_wr_cdr_trans
);

  localparam int MW = mst_idx_width(NUMBER_MASTER);
  localparam int SW = slv_idx_width(NUMBER_SLAVE);

  logic [NUMBER_MASTER-1:0]                    busy;
  logic [NUMBER_SLAVE-1:0][NUMBER_MASTER-1:0]  req;

  // A master already holding any grant is masked so it can own only one slave.
  always_comb begin
    busy = '0;
    req  = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      for (int j = 0; j < NUMBER_SLAVE; j++) begin
        busy[i] = busy[i] | grant_wr[j][i];
      end
    end
    for (int j = 0; j < NUMBER_SLAVE; j++) begin
      for (int i = 0; i < NUMBER_MASTER; i++) begin
        req[j][i] = m_axil_awvalid[i] & ~busy[i] &
                    (m_axil_awaddr[i][AXI_ADDR_WIDTH-1 -: SW] == SW'(j));
      end
    end
  end

  for (genvar j = 0; j < NUMBER_SLAVE; j++) begin : g_slv
    axil_wr_arb_state_t        state_q, state_d;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [MW-1:0]             ptr_q, ptr_d, win_idx, cdr_q, cdr_d;
    logic [NUMBER_MASTER-1:0]  win_oh, gnt_q, gnt_d;
    logic                      win_any;

    axil_rr_arbiter #(.NUMBER_MASTER(NUMBER_MASTER)) u_rr (
      .req       (req[j]),
      .ptr       (ptr_q),
      .grant     (win_oh),
      .grant_idx (win_idx),
      .valid     (win_any)
    );

    always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      cdr_d     = cdr_q;
      case (state_q)
        IDLE: begin
          if (win_any) begin
            gnt_d     = win_oh;
            cdr_d     = win_idx;
            ptr_d     = (win_idx == MW'(NUMBER_MASTER - 1)) ? '0 : win_idx + MW'(1);
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = ADDR_DATA;
          end
        end
        ADDR_DATA: begin
          // Done flags include this cycle's handshake so AW and W may finish together.
          aw_done_d = aw_done_q | (s_axil_awvalid[j] & s_axil_awready[j]);
          w_done_d  = w_done_q  | (s_axil_wvalid[j]  & s_axil_wready[j]);
          if (aw_done_d && w_done_d) state_d = RESP;
        end
        RESP: begin
          if (s_axil_bvalid[j] && s_axil_bready[j]) begin
            gnt_d   = '0;
            cdr_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        state_q   <= IDLE;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        ptr_q     <= '0;
        gnt_q     <= '0;
        cdr_q     <= '0;
      end else begin
        state_q   <= state_d;
        aw_done_q <= aw_done_d;
        w_done_q  <= w_done_d;
        ptr_q     <= ptr_d;
        gnt_q     <= gnt_d;
        cdr_q     <= cdr_d;
      end
    end

    assign grant_wr[j]     = gnt_q;
    assign grant_wr_cdr[j] = cdr_q;
  end

  always_comb begin
    grant_wr_trans     = '0;
    grant_wr_cdr_trans = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      for (int j = 0; j < NUMBER_SLAVE; j++) begin
        grant_wr_trans[i][j] = grant_wr[j][i];
        if (grant_wr[j][i]) grant_wr_cdr_trans[i] = SW'(j);
      end
    end
  end

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Directed bench for axil_arbiter_wr: single write, contention, parallel, W-first, busy mask, reset.
module tb_axil_arbiter_wr;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [2:0][7:0]  m_axil_awaddr;
  logic [2:0]       m_axil_awvalid;
  logic [3:0]       s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [3:0]       s_axil_bvalid, s_axil_bready;
  logic [3:0][2:0]  grant_wr;
  logic [3:0][1:0]  grant_wr_cdr;
  logic [2:0][3:0]  grant_wr_trans;
  logic [2:0][1:0]  grant_wr_cdr_trans;

  int total = 0;
  int bad   = 0;

  axil_arbiter_wr dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .m_axil_awaddr      (m_axil_awaddr),
    .m_axil_awvalid     (m_axil_awvalid),
    .s_axil_awvalid     (s_axil_awvalid),
    .s_axil_awready     (s_axil_awready),
    .s_axil_wvalid      (s_axil_wvalid),
    .s_axil_wready      (s_axil_wready),
    .s_axil_bvalid      (s_axil_bvalid),
    .s_axil_bready      (s_axil_bready),
    .grant_wr           (grant_wr),
    .grant_wr_cdr       (grant_wr_cdr),
    .grant_wr_trans     (grant_wr_trans),
    .grant_wr_cdr_trans (grant_wr_cdr_trans)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // One-cycle AW+W handshake, then one-cycle B handshake on slave j.
  task automatic serve(input int j);
    s_axil_awvalid[j] = 1'b1; s_axil_awready[j] = 1'b1;
    s_axil_wvalid[j]  = 1'b1; s_axil_wready[j]  = 1'b1;
    step();
    s_axil_awvalid[j] = 1'b0; s_axil_awready[j] = 1'b0;
    s_axil_wvalid[j]  = 1'b0; s_axil_wready[j]  = 1'b0;
    s_axil_bvalid[j]  = 1'b1; s_axil_bready[j]  = 1'b1;
    step();
    s_axil_bvalid[j]  = 1'b0; s_axil_bready[j]  = 1'b0;
  endtask

  initial begin
    logic [2:0] cont_exp [4];
    cont_exp[0] = 3'b001; cont_exp[1] = 3'b010; cont_exp[2] = 3'b100; cont_exp[3] = 3'b001;

    aresetn = 1'b0;
    m_axil_awaddr = '0; m_axil_awvalid = '0;
    s_axil_awvalid = '0; s_axil_awready = '0; s_axil_wvalid = '0; s_axil_wready = '0;
    s_axil_bvalid = '0; s_axil_bready = '0;
    step(); step();
    chk("rst grant_wr", 32'(grant_wr), 32'h0);
    chk("rst grant_wr_cdr", 32'(grant_wr_cdr), 32'h0);
    chk("rst grant_wr_trans", 32'(grant_wr_trans), 32'h0);
    chk("rst grant_wr_cdr_trans", 32'(grant_wr_cdr_trans), 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();

    // Single write M1 -> 0x85 (slave 2)
    m_axil_awaddr[1] = 8'h85; m_axil_awvalid[1] = 1'b1;
    step();
    chk("single grant_wr[2]", 32'(grant_wr[2]), 32'h2);
    chk("single grant_wr_cdr[2]", 32'(grant_wr_cdr[2]), 32'h1);
    chk("single trans[1]", 32'(grant_wr_trans[1]), 32'h4);
    chk("single cdr_trans[1]", 32'(grant_wr_cdr_trans[1]), 32'h2);
    chk("single other slaves", 32'({grant_wr[3], grant_wr[1], grant_wr[0]}), 32'h0);
    m_axil_awvalid[1] = 1'b0;
    s_axil_awvalid[2] = 1'b1; s_axil_awready[2] = 1'b1;
    s_axil_wvalid[2]  = 1'b1; s_axil_wready[2]  = 1'b1;
    step();
    s_axil_awvalid[2] = 1'b0; s_axil_awready[2] = 1'b0;
    s_axil_wvalid[2]  = 1'b0; s_axil_wready[2]  = 1'b0;
    chk("single hold after aw/w", 32'(grant_wr[2]), 32'h2);
    s_axil_bvalid[2] = 1'b1; s_axil_bready[2] = 1'b1;
    #2;
    chk("single hold in b cycle", 32'(grant_wr[2]), 32'h2);
    step();
    s_axil_bvalid[2] = 1'b0; s_axil_bready[2] = 1'b0;
    chk("single clear grant_wr[2]", 32'(grant_wr[2]), 32'h0);
    chk("single clear cdr_trans[1]", 32'(grant_wr_cdr_trans[1]), 32'h0);
    chk("single clear trans[1]", 32'(grant_wr_trans[1]), 32'h0);

    // Contention: all masters to 0x10 (slave 0)
    m_axil_awaddr[0] = 8'h10; m_axil_awaddr[1] = 8'h10; m_axil_awaddr[2] = 8'h10;
    m_axil_awvalid = 3'b111;
    step();
    chk("cont grant 0", 32'(grant_wr[0]), 32'(cont_exp[0]));
    for (int k = 1; k < 4; k++) begin
      serve(0);
      chk($sformatf("cont idle gap %0d", k), 32'(grant_wr[0]), 32'h0);
      step();
      chk($sformatf("cont grant %0d", k), 32'(grant_wr[0]), 32'(cont_exp[k]));
    end
    serve(0);
    m_axil_awvalid = 3'b000;
    step();
    chk("cont no regrant", 32'(grant_wr[0]), 32'h0);

    // Parallel: M0 -> 0x00 (S0), M2 -> 0xC0 (S3)
    m_axil_awaddr[0] = 8'h00; m_axil_awaddr[2] = 8'hC0;
    m_axil_awvalid = 3'b101;
    step();
    m_axil_awvalid = 3'b000;
    chk("par grant_wr[0]", 32'(grant_wr[0]), 32'h1);
    chk("par grant_wr[3]", 32'(grant_wr[3]), 32'h4);
    chk("par cdr_trans[2]", 32'(grant_wr_cdr_trans[2]), 32'h3);
    chk("par trans[2]", 32'(grant_wr_trans[2]), 32'h8);
    chk("par cdr_trans[0]", 32'(grant_wr_cdr_trans[0]), 32'h0);
    serve(3);
    chk("par s3 cleared", 32'(grant_wr[3]), 32'h0);
    chk("par s0 still held", 32'(grant_wr[0]), 32'h1);
    serve(0);
    chk("par s0 cleared", 32'(grant_wr[0]), 32'h0);

    // W accepted three cycles before AW on S1; B held high while AW is pending
    m_axil_awaddr[1] = 8'h40; m_axil_awvalid[1] = 1'b1;
    step();
    m_axil_awvalid[1] = 1'b0;
    chk("wfirst grant", 32'(grant_wr[1]), 32'h2);
    s_axil_wvalid[1] = 1'b1; s_axil_wready[1] = 1'b1;
    step();
    s_axil_wvalid[1] = 1'b0; s_axil_wready[1] = 1'b0;
    chk("wfirst hold after w", 32'(grant_wr[1]), 32'h2);
    s_axil_bvalid[1] = 1'b1; s_axil_bready[1] = 1'b1;
    step();
    chk("wfirst hold wait 1", 32'(grant_wr[1]), 32'h2);
    step();
    chk("wfirst hold wait 2", 32'(grant_wr[1]), 32'h2);
    s_axil_bvalid[1] = 1'b0; s_axil_bready[1] = 1'b0;
    s_axil_awvalid[1] = 1'b1; s_axil_awready[1] = 1'b1;
    step();
    s_axil_awvalid[1] = 1'b0; s_axil_awready[1] = 1'b0;
    chk("wfirst hold after aw", 32'(grant_wr[1]), 32'h2);

    // Busy mask: M1 still owns S1 (RESP) and requests S0
    m_axil_awaddr[1] = 8'h00; m_axil_awvalid[1] = 1'b1;
    step();
    chk("busy s0 masked 1", 32'(grant_wr[0]), 32'h0);
    step();
    chk("busy s0 masked 2", 32'(grant_wr[0]), 32'h0);
    chk("busy s1 held", 32'(grant_wr[1]), 32'h2);
    s_axil_bvalid[1] = 1'b1; s_axil_bready[1] = 1'b1;
    step();
    s_axil_bvalid[1] = 1'b0; s_axil_bready[1] = 1'b0;
    chk("busy s1 cleared", 32'(grant_wr[1]), 32'h0);
    chk("busy s0 still masked", 32'(grant_wr[0]), 32'h0);
    step();
    chk("busy s0 granted", 32'(grant_wr[0]), 32'h2);
    chk("busy cdr_trans[1]", 32'(grant_wr_cdr_trans[1]), 32'h0);
    chk("busy trans[1]", 32'(grant_wr_trans[1]), 32'h1);
    m_axil_awvalid[1] = 1'b0;
    serve(0);
    chk("busy s0 cleared", 32'(grant_wr[0]), 32'h0);

    // Reset during RESP with M0 holding S2
    m_axil_awaddr[0] = 8'h80; m_axil_awvalid[0] = 1'b1;
    step();
    m_axil_awvalid[0] = 1'b0;
    chk("rstmid grant", 32'(grant_wr[2]), 32'h1);
    s_axil_awvalid[2] = 1'b1; s_axil_awready[2] = 1'b1;
    s_axil_wvalid[2]  = 1'b1; s_axil_wready[2]  = 1'b1;
    step();
    s_axil_awvalid[2] = 1'b0; s_axil_awready[2] = 1'b0;
    s_axil_wvalid[2]  = 1'b0; s_axil_wready[2]  = 1'b0;
    chk("rstmid resp hold", 32'(grant_wr[2]), 32'h1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rstmid grant_wr async", 32'(grant_wr), 32'h0);
    chk("rstmid trans async", 32'(grant_wr_trans), 32'h0);
    chk("rstmid cdr async", 32'(grant_wr_cdr), 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_axil_awaddr[1] = 8'h80; m_axil_awvalid[1] = 1'b1;
    step();
    m_axil_awvalid[1] = 1'b0;
    chk("post-rst grant", 32'(grant_wr[2]), 32'h2);
    chk("post-rst cdr", 32'(grant_wr_cdr[2]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_wr.md
Name: axil_arbiter_wr

Overview:
Write-channel arbiter for the AXI-Lite interconnect.
- Decodes each master's AW address to a target slave.
- Runs one round-robin arbiter per slave.
- Holds each grant for a full AW/W/B transaction.
- Drives the one-hot and index grant buses that steer the write crossbar datapath (master-to-slave and slave-to-master directions).

Parameters:
NUMBER_MASTER, 3, number of AXI-Lite write masters (>=2)
NUMBER_SLAVE, 4, number of AXI-Lite write slaves (>=2)
AXI_ADDR_WIDTH, 8, address width; slave index = awaddr[AXI_ADDR_WIDTH-1 -: $clog2(NUMBER_SLAVE)]

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  reset, asynchronous assert, active-low
m_axil_awaddr  in  [AXI_ADDR_WIDTH-1:0] x NUMBER_MASTER  master AW addresses (decode only)
m_axil_awvalid  in  [NUMBER_MASTER-1:0]  master AW valid (request)
s_axil_awvalid  in  [NUMBER_SLAVE-1:0]  slave-side AW valid (crossbar output)
s_axil_awready  in  [NUMBER_SLAVE-1:0]  slave AW ready
s_axil_wvalid  in  [NUMBER_SLAVE-1:0]  slave-side W valid
s_axil_wready  in  [NUMBER_SLAVE-1:0]  slave W ready
s_axil_bvalid  in  [NUMBER_SLAVE-1:0]  slave B valid
s_axil_bready  in  [NUMBER_SLAVE-1:0]  slave-side B ready
grant_wr  out  [NUMBER_MASTER-1:0] x NUMBER_SLAVE  one-hot granted master per slave
grant_wr_cdr  out  [$clog2(NUMBER_MASTER)-1:0] x NUMBER_SLAVE  granted master index per slave
grant_wr_trans  out  [NUMBER_SLAVE-1:0] x NUMBER_MASTER  transpose: one-hot granted slave per master
grant_wr_cdr_trans  out  [$clog2(NUMBER_SLAVE)-1:0] x NUMBER_MASTER  granted slave index per master

Behaviour:
- Reset (aresetn=0, async): all grant outputs 0, all cdr outputs 0, every slave FSM in IDLE, every RR pointer 0.
- Request: req[j][i] = m_axil_awvalid[i] & (decoded index of master i == j) & ~busy[i]. busy[i] = master i holds a grant at any slave. Decoded index >= NUMBER_SLAVE is never granted; integration must map such addresses.
- Per-slave FSM, all outputs registered:
  - IDLE: if any req[j], pick the first requesting master at or after ptr[j] (cyclic). Register grant_wr[j], grant_wr_cdr[j]; ptr[j] <= winner+1 mod NUMBER_MASTER; go to ADDR_DATA.
  - ADDR_DATA: set aw_done on s_awvalid&s_awready and w_done on s_wvalid&s_wready. AW and W may complete in either order or in the same cycle. When both are done (including the completing cycle), go to RESP.
  - RESP: on s_bvalid&s_bready, clear grant_wr[j] and grant_wr_cdr[j] on the next edge; go to IDLE.
- Latency: request seen in cycle N -> grant visible in cycle N+1. B handshake in cycle M -> grant low in cycle M+1. Earliest re-grant is cycle M+2 (one mandatory IDLE cycle).
- Grant stability: grant_wr[j] stays constant from assertion until the cycle after the B handshake, even if m_axil_awvalid drops after AW acceptance.
- Exclusivity: at most one bit set per grant_wr[j]; a master is granted at no more than one slave.
- Simultaneous events: if two slaves' IDLE arbitration picks the same master in one cycle, that cannot happen because decode is unique per master. A B handshake and a new request in the same cycle: the request is served after IDLE.
- Transpose: grant_wr_trans[i][j] = grant_wr[j][i]; grant_wr_cdr_trans[i] = index of the set bit, else 0. Purely combinational from registered grants, so there is no extra latency.
- Reset mid-transaction: grants drop immediately (async); pointers return to 0.

Decomposition:
- Package axil_interconnect_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} axil_wr_arb_state_t
  - slave-index-width and master-index-width helper functions
- One sub-module, axil_rr_arbiter: parameterised NUMBER_MASTER round-robin picker with req vector and pointer in, one-hot and index out. Purely combinational.
- Instantiate it NUMBER_SLAVE times inside generate.

Test Plan:
- Single write, defaults: M1 awaddr=0x85 (slave 2), awvalid=1 -> grant_wr[2]=3'b010, grant_wr_cdr[2]=1, grant_wr_trans[1]=4'b0100, grant_wr_cdr_trans[1]=2 next cycle. Grant holds through AW/W. It clears the cycle after the B handshake.
- Contention: M0, M1, M2 all target 0x10 (slave 0) continuously with 1-cycle slave responses -> grant order M0, M1, M2, M0. At least one idle cycle between grants.
- Parallel: M0->0x00 (S0), M2->0xC0 (S3) in the same cycle -> both grants assert in the same cycle, independent completion.
- W before AW: slave accepts W 3 cycles before AW -> FSM stays in ADDR_DATA until AW, then RESP. Grant is never dropped early.
- Busy mask: M1 holds S1 and raises a second awvalid to 0x00 during RESP -> S0 does not grant M1 until M1's S1 grant clears.
- Reset mid-RESP: aresetn=0 while grant_wr[2]=3'b001 -> all grants 0 immediately. After release, M1 requesting wins first (pointer 0, M0 idle).
